// File: rtl/decode_regfile_dump.sv
// decode_regfile_dump
// Decode-stage register file: NUM_READ combinational read ports, one
// synchronous write port, write-through forwarding on every read port and
// register 0 hardwired to zero.
// Optional dump engine (macro REGFILE_DUMP_EN): after a one-cycle start
// request it streams registers 0..DEPTH-1 over a valid/ready handshake to
// the debug unit. Without the macro the dump ports are tied to zero and the
// dump inputs are ignored; the port list is the same in both builds.
module decode_regfile_dump #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_RegWrite,
    input  logic [ADDR_W-1:0]            i_addr_data,
    input  logic [DATA_W-1:0]            i_data,
    input  logic [NUM_READ*ADDR_W-1:0]   i_raddr,
    output logic [NUM_READ*DATA_W-1:0]   o_rdata,
    input  logic                         i_dump_start,
    input  logic                         i_dump_ready,
    output logic                         o_dump_valid,
    output logic [ADDR_W-1:0]            o_dump_addr,
    output logic [DATA_W-1:0]            o_dump_data,
    output logic                         o_dump_busy,
    output logic                         o_dump_done
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    // Storage. Entry 0 is never written, so it stays at its reset value.
    logic [DATA_W-1:0] regs_r [DEPTH];

    // A write only counts when it targets a real register.
    logic wr_en_s;
    assign wr_en_s = i_RegWrite && (i_addr_data != ZERO_ADDR);

    // Read rule shared by the read ports and the dump engine:
    // address 0 reads zero, a same-cycle write to the address is forwarded,
    // otherwise the stored value is returned.
    function automatic logic [DATA_W-1:0] read_word(
        input logic [ADDR_W-1:0] addr,
        input logic              wr_en,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] word;
        if (addr == ZERO_ADDR) begin
            word = {DATA_W{1'b0}};
        end else if (wr_en && (waddr == addr)) begin
            word = wdata;
        end else begin
            word = stored;
        end
        return word;
    endfunction

    // Register array: cleared on reset, written on the rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[i_addr_data] <= i_data;
        end
    end

    // Combinational read ports with write-through forwarding.
    always_comb begin
        o_rdata = {(NUM_READ*DATA_W){1'b0}};
        for (int k = 0; k < NUM_READ; k++) begin
            o_rdata[k*DATA_W +: DATA_W] = read_word(
                i_raddr[k*ADDR_W +: ADDR_W],
                wr_en_s,
                i_addr_data,
                i_data,
                regs_r[i_raddr[k*ADDR_W +: ADDR_W]]
            );
        end
    end

`ifdef REGFILE_DUMP_EN

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } dump_state_e;

    dump_state_e       state_r;
    dump_state_e       state_nxt_s;
    logic [ADDR_W-1:0] idx_r;
    logic [ADDR_W-1:0] idx_nxt_s;
    logic              valid_s;
    logic              busy_s;
    logic              done_s;
    logic [DATA_W-1:0] dump_word_s;

    // Dump state and word index; reset aborts any dump in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            idx_r   <= ZERO_ADDR;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Next-state logic and state-decoded handshake flags.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        valid_s     = 1'b0;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_dump_start) begin
                    state_nxt_s = ST_SEND;
                    idx_nxt_s   = ZERO_ADDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                valid_s = 1'b1;
                busy_s  = 1'b1;
                if (i_dump_ready) begin
                    if (idx_r == LAST_ADDR) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        idx_nxt_s = idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    // Consumer stalled: hold the current word.
                    idx_nxt_s = idx_r;
                end
            end
            ST_DONE: begin
                busy_s      = 1'b1;
                done_s      = 1'b1;
                idx_nxt_s   = ZERO_ADDR;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = ZERO_ADDR;
            end
        endcase
    end

    // Current dump word; tracks a same-cycle write to the held address.
    always_comb begin
        dump_word_s = {DATA_W{1'b0}};
        if (state_r == ST_SEND) begin
            dump_word_s = read_word(idx_r, wr_en_s, i_addr_data, i_data,
                                    regs_r[idx_r]);
        end else begin
            dump_word_s = {DATA_W{1'b0}};
        end
    end

    assign o_dump_valid = valid_s;
    assign o_dump_busy  = busy_s;
    assign o_dump_done  = done_s;
    assign o_dump_addr  = (state_r == ST_SEND) ? idx_r : ZERO_ADDR;
    assign o_dump_data  = dump_word_s;

`else

    // Dump engine absent: inputs are ignored, outputs are constant zero.
    logic unused_dump_s;
    assign unused_dump_s = i_dump_start ^ i_dump_ready;

    assign o_dump_valid = 1'b0;
    assign o_dump_busy  = 1'b0;
    assign o_dump_done  = 1'b0;
    assign o_dump_addr  = {ADDR_W{1'b0}};
    assign o_dump_data  = {DATA_W{1'b0}};

`endif

endmodule

// File: tb/tb_decode_regfile_dump.sv
// Directed bench for decode_regfile_dump (default parameters 32x32, 2 ports).
// Dump scenarios run when REGFILE_DUMP_EN is defined; otherwise the bench
// checks that the dump ports stay quiet.
module tb_decode_regfile_dump;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_READ = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic        dump_start;
    logic        dump_ready;
    logic        dump_valid;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_busy;
    logic        dump_done;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_mem [32];

    always #5 clk = ~clk;

    decode_regfile_dump #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_READ (NUM_READ)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_RegWrite   (reg_write),
        .i_addr_data  (waddr),
        .i_data       (wdata),
        .i_raddr      (raddr),
        .o_rdata      (rdata),
        .i_dump_start (dump_start),
        .i_dump_ready (dump_ready),
        .o_dump_valid (dump_valid),
        .o_dump_addr  (dump_addr),
        .o_dump_data  (dump_data),
        .o_dump_busy  (dump_busy),
        .o_dump_done  (dump_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) exp_mem[i] = 32'd0;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        reg_write = 1'b1;
        waddr     = a;
        wdata     = d;
        step();
        reg_write = 1'b0;
        if (a != 5'd0) exp_mem[a] = d;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : exp_mem[a];
    endfunction

    task automatic test_reset();
        raddr = {5'd2, 5'd1};
        step();
        step();
        checks++;
        if (rdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected %h", rdata, 64'd0);
        end
        checks++;
        if ({dump_valid, dump_busy, dump_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {dump_valid, dump_busy, dump_done});
        end
        checks++;
        if ({dump_addr, dump_data} !== 37'd0) begin
            errors++;
            $display("FAIL reset_dump_word: got %h/%h expected 0/0", dump_addr, dump_data);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic_rw();
        write_reg(5'd1, 32'h0000_0002);
        write_reg(5'd2, 32'h0000_0003);
        raddr = {5'd2, 5'd1};
        #1;
        checks++;
        if (rdata !== {32'h0000_0003, 32'h0000_0002}) begin
            errors++;
            $display("FAIL read_2_1: got %h expected %h", rdata, {32'h3, 32'h2});
        end
        raddr = {5'd1, 5'd2};
        #1;
        checks++;
        if (rdata !== {32'h0000_0002, 32'h0000_0003}) begin
            errors++;
            $display("FAIL read_1_2: got %h expected %h", rdata, {32'h2, 32'h3});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rdata !== 64'd0) begin
            errors++;
            $display("FAIL read_after_reset: got %h expected 0", rdata);
        end
        clear_model();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_zero_reg();
        reg_write = 1'b1;
        waddr     = 5'd0;
        wdata     = 32'hDEAD_BEEF;
        raddr     = {5'd0, 5'd0};
        #1;
        checks++;
        if (rdata !== 64'd0) begin
            errors++;
            $display("FAIL zero_fwd: got %h expected 0", rdata);
        end
        step();
        reg_write = 1'b0;
        #1;
        checks++;
        if (rdata !== 64'd0) begin
            errors++;
            $display("FAIL zero_stored: got %h expected 0", rdata);
        end
    endtask

    task automatic test_forward();
        write_reg(5'd5, 32'h0000_0011);
        reg_write = 1'b1;
        waddr     = 5'd5;
        wdata     = 32'h0000_000F;
        raddr     = {5'd6, 5'd5};
        #1;
        checks++;
        if (rdata[31:0] !== 32'h0000_000F) begin
            errors++;
            $display("FAIL fwd_before_edge: got %h expected %h", rdata[31:0], 32'hF);
        end
        checks++;
        if (rdata[63:32] !== 32'd0) begin
            errors++;
            $display("FAIL fwd_other_port: got %h expected 0", rdata[63:32]);
        end
        raddr = {5'd5, 5'd5};
        #1;
        checks++;
        if (rdata !== {32'h0000_000F, 32'h0000_000F}) begin
            errors++;
            $display("FAIL fwd_same_addr: got %h expected %h", rdata, {32'hF, 32'hF});
        end
        step();
        exp_mem[5] = 32'h0000_000F;
        reg_write  = 1'b0;
        raddr      = {5'd6, 5'd5};
        #1;
        checks++;
        if (rdata[31:0] !== 32'h0000_000F) begin
            errors++;
            $display("FAIL fwd_after_edge: got %h expected %h", rdata[31:0], 32'hF);
        end
    endtask

`ifdef REGFILE_DUMP_EN

    task automatic test_dump_full();
        for (int k = 1; k < 32; k++) write_reg(5'(k), 32'(k + 1));
        dump_ready = 1'b1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dump_start = (i == 5);
            #1;
            checks++;
            if (!(dump_valid === 1'b1 && dump_busy === 1'b1 && dump_done === 1'b0 &&
                  dump_addr === 5'(i) && dump_data === exp_read(5'(i)))) begin
                errors++;
                $display("FAIL dump_word_%0d: got v%b b%b d%b addr %0d data %h expected v1 b1 d0 addr %0d data %h",
                         i, dump_valid, dump_busy, dump_done, dump_addr, dump_data, i, exp_read(5'(i)));
            end
            step();
            dump_start = 1'b0;
        end
        dump_start = 1'b1;
        #1;
        checks++;
        if ({dump_done, dump_busy, dump_valid} !== 3'b110) begin
            errors++;
            $display("FAIL dump_done_pulse: got done/busy/valid %b expected 110", {dump_done, dump_busy, dump_valid});
        end
        step();
        dump_start = 1'b0;
        #1;
        checks++;
        if ({dump_done, dump_busy, dump_valid} !== 3'b000) begin
            errors++;
            $display("FAIL dump_idle_after: got done/busy/valid %b expected 000", {dump_done, dump_busy, dump_valid});
        end
        step();
    endtask

    task automatic test_dump_stall();
        logic [3:0]  pat;
        logic [31:0] exp_data;
        logic        do_wr;
        logic        accepted;
        logic        wrote;
        int          exp;
        int          cyc;
        pat   = 4'b1001;
        wrote = 1'b0;
        exp   = 0;
        cyc   = 0;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        while (exp < 32 && cyc < 400) begin
            dump_ready = pat[cyc % 4];
            do_wr = !dump_ready && !wrote && exp >= 5;
            if (do_wr) begin
                reg_write = 1'b1;
                waddr     = 5'(exp);
                wdata     = 32'hFFFF_FFFF;
            end
            raddr = {5'd7, 5'd3};
            #1;
            exp_data = do_wr ? 32'hFFFF_FFFF : exp_read(5'(exp));
            checks++;
            if (!(dump_valid === 1'b1 && dump_addr === 5'(exp) && dump_data === exp_data)) begin
                errors++;
                $display("FAIL stall_word_cyc%0d: got v%b addr %0d data %h expected v1 addr %0d data %h",
                         cyc, dump_valid, dump_addr, dump_data, exp, exp_data);
            end
            if (cyc == 2) begin
                checks++;
                if (rdata !== {exp_read(5'd7), exp_read(5'd3)}) begin
                    errors++;
                    $display("FAIL read_during_dump: got %h expected %h", rdata, {exp_read(5'd7), exp_read(5'd3)});
                end
            end
            accepted = dump_ready;
            step();
            if (do_wr) begin
                reg_write    = 1'b0;
                exp_mem[exp] = 32'hFFFF_FFFF;
                wrote        = 1'b1;
            end
            if (accepted) exp++;
            cyc++;
        end
        checks++;
        if (exp != 32 || !wrote) begin
            errors++;
            $display("FAIL stall_timeout: got %0d words expected 32 (write done %b)", exp, wrote);
        end
        #1;
        checks++;
        if ({dump_done, dump_valid} !== 2'b10) begin
            errors++;
            $display("FAIL stall_done: got done/valid %b expected 10", {dump_done, dump_valid});
        end
        step();
    endtask

    task automatic test_dump_abort();
        logic bad;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        repeat (10) step();
        checks++;
        if (!(dump_valid === 1'b1 && dump_addr === 5'd10)) begin
            errors++;
            $display("FAIL abort_index: got v%b addr %0d expected v1 addr 10", dump_valid, dump_addr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({dump_valid, dump_busy, dump_done} !== 3'b000) begin
            errors++;
            $display("FAIL abort_flags: got %b expected 000", {dump_valid, dump_busy, dump_done});
        end
        clear_model();
        step();
        step();
        rst = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (dump_done !== 1'b0 || dump_valid !== 1'b0) bad = 1'b1;
            step();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL abort_no_done: got activity after abort expected none");
        end
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        #1;
        checks++;
        if (!(dump_valid === 1'b1 && dump_addr === 5'd0 && dump_data === 32'd0)) begin
            errors++;
            $display("FAIL restart_addr0: got v%b addr %0d data %h expected v1 addr 0 data 0",
                     dump_valid, dump_addr, dump_data);
        end
        repeat (32) step();
        checks++;
        if (dump_done !== 1'b1) begin
            errors++;
            $display("FAIL restart_done: got %b expected 1", dump_done);
        end
        step();
    endtask

`else

    task automatic test_dump_disabled();
        logic bad;
        bad = 1'b0;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        checks++;
        if (dump_valid !== 1'b0) begin
            errors++;
            $display("FAIL disabled_start: got valid %b expected 0", dump_valid);
        end
        for (int i = 0; i < 40; i++) begin
            dump_ready = i[0];
            dump_start = (i % 7 == 0);
            #1;
            if ({dump_valid, dump_busy, dump_done} !== 3'b000 ||
                dump_addr !== 5'd0 || dump_data !== 32'd0) bad = 1'b1;
            step();
        end
        dump_start = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL disabled_quiet: got dump activity expected none");
        end
    endtask

`endif

    initial begin
        rst        = 1'b0;
        reg_write  = 1'b0;
        waddr      = 5'd0;
        wdata      = 32'd0;
        raddr      = 10'd0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        clear_model();

        test_reset();
        test_basic_rw();
        test_zero_reg();
        test_forward();
`ifdef REGFILE_DUMP_EN
        test_dump_full();
        test_dump_stall();
        test_dump_abort();
`else
        test_dump_disabled();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_regfile_dump.md
Name: decode_regfile_dump

Overview:
- Parametrised register file for the decode stage: NUM_READ combinational read ports and one synchronous write port.
- Write-through forwarding on every read port; register 0 hardwired to zero.
- Sequential dump engine streams every register over a valid/ready handshake to the debug unit after the pipeline halts.
- Successor to the fixed 32x32, 2-read register file inside the decode stage.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_READ, 2, number of independent read ports (1..4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- i_RegWrite  in  1  write enable (from writeback)
- i_addr_data  in  ADDR_W  write address
- i_data  in  DATA_W  write data
- i_raddr  in  NUM_READ*ADDR_W  packed read addresses; port k at [k*ADDR_W +: ADDR_W]
- o_rdata  out  NUM_READ*DATA_W  packed read data; port k at [k*DATA_W +: DATA_W]
- i_dump_start  in  1  one-cycle request to start a dump
- i_dump_ready  in  1  consumer accepts the current dump word
- o_dump_valid  out  1  dump word valid
- o_dump_addr  out  ADDR_W  index of the current dump word
- o_dump_data  out  DATA_W  content of the current dump word
- o_dump_busy  out  1  dump in progress
- o_dump_done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (rst=0, asynchronous):
  - All DEPTH registers cleared to 0; FSM to IDLE.
  - o_dump_valid=0, o_dump_addr=0, o_dump_busy=0, o_dump_done=0; o_dump_data=0.
  - Reset asserted mid-dump aborts the dump; no done pulse is produced.
- Write:
  - On a rising edge with i_RegWrite=1 and i_addr_data!=0, reg[i_addr_data] <= i_data.
  - Writes to address 0 are discarded.
- Read (combinational, zero latency), per port k:
  - raddr_k==0 -> 0.
  - Else if i_RegWrite=1 and i_addr_data==raddr_k -> i_data (forwarding).
  - Else -> reg[raddr_k].
  - Identical addresses on several ports return identical data.
- Dump FSM states IDLE, SEND, DONE:
  - IDLE: valid=0, busy=0. i_dump_start=1 -> SEND with index=0.
  - SEND: busy=1, valid=1, o_dump_addr=index, o_dump_data = read of index using the same zero and forwarding rules as the read ports.
    - valid & ready and index<DEPTH-1 -> index+1, stay in SEND.
    - valid & ready and index==DEPTH-1 -> DONE.
    - ready=0 -> hold addr; data follows any write to that address.
  - DONE: done=1 and busy=1 for exactly one cycle, valid=0; index <= 0; -> IDLE.
  - i_dump_start is ignored in SEND and DONE; no queuing.
  - Index wraps nowhere: exactly DEPTH words per dump, addresses 0..DEPTH-1 in order.
- Normal reads and writes continue unaffected during a dump.

Optional Feature:
- Macro REGFILE_DUMP_EN.
- Defined: dump FSM and dump ports behave as specified above.
- Undefined:
  - FSM not instantiated; o_dump_valid, o_dump_busy and o_dump_done tied 0; o_dump_addr and o_dump_data tied 0.
  - i_dump_start and i_dump_ready ignored.
  - Read/write behaviour unchanged; port list unchanged.

Test Plan:
1. Reset, then write reg1=0x00000002, reg2=0x00000003; raddr={2,1} -> o_rdata={0x00000003,0x00000002}. Assert rst=0 -> both read 0.
2. Write 0xDEADBEEF to addr 0, read addr 0 -> 0x00000000 on every port.
3. Same cycle i_RegWrite=1, addr 5, data 0x0000000F, raddr port0=5 -> o_rdata port0=0x0000000F before the edge, and still 0x0000000F after the edge.
4. Load reg k=k+1, pulse start with ready=1 -> 32 consecutive words addr 0..31, data 0,2,3,...,32 (reg0 reads 0); done pulses one cycle after addr 31; then busy=0.
5. Dump with ready toggling 1,0,0,1 -> addr holds while ready=0; a write of 0xFFFFFFFF to the held address appears on o_dump_data in the same cycle; no word skipped or repeated.
6. Assert rst at dump index 10 -> valid, busy and done drop immediately with no done pulse; a new start restarts at addr 0. With REGFILE_DUMP_EN undefined, start gives valid=0 permanently.
